// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch resolve unit.
package bp_pkg;

  localparam int unsigned BP_XLEN        = 32;
  localparam int unsigned BP_GHR_SIZE    = 9;
  localparam int unsigned BP_PHT_ADDRESS = 9;
  localparam int unsigned BP_RAS_ADDRESS = 3;
  localparam int unsigned BP_DEPTH       = 8;

  // log2 of a power-of-two depth, never narrower than one bit
  function automatic int unsigned tag_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) <= depth) w = i;
    end
    return w;
  endfunction

  localparam int unsigned BP_TAGW = tag_width(BP_DEPTH);

  // Everything the predictor knew when it made the prediction
  typedef struct packed {
    logic                        pred_taken;
    logic [BP_XLEN-1:0]          pred_target;
    logic [BP_PHT_ADDRESS-1:0]   pht_index;
    logic [BP_GHR_SIZE-1:0]      ghr;
    logic [BP_RAS_ADDRESS-1:0]   sp_snap;
    logic [2*BP_XLEN-1:0]        ras_snap;
  } bp_ckpt_t;

  // Wrong direction, or right direction (taken) but wrong target
  function automatic logic bp_mispredict(input logic               res_taken,
                                         input logic [BP_XLEN-1:0] res_target,
                                         input bp_ckpt_t           ck);
    return (res_taken != ck.pred_taken) || (res_taken && (res_target != ck.pred_target));
  endfunction

endpackage

// File: rtl/branch_ckpt_queue.sv
// In-order checkpoint queue: alloc at tail, resolve by tag, retire at head, squash on mispredict.
module branch_ckpt_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = BP_DEPTH
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         alloc_valid,
  input  bp_ckpt_t                     alloc_entry,
  output logic                         alloc_ready,
  output logic [tag_width(DEPTH)-1:0]  alloc_tag,
  input  logic                         res_valid,
  input  logic [tag_width(DEPTH)-1:0]  res_tag,
  input  logic                         res_mispredict,
  output logic                         res_accept,
  output bp_ckpt_t                     res_entry
);

  localparam int unsigned TAGW = tag_width(DEPTH);
  localparam int unsigned PtrW = TAGW + 1;

  bp_ckpt_t          mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d, resolved_q, resolved_d;
  logic [TAGW:0]     head_q, head_d, tail_q, tail_d;
  logic              full, empty, alloc_fire, retire, squash;
  logic [TAGW-1:0]   head_idx, tail_idx, res_off, off_i;

  assign head_idx    = head_q[TAGW-1:0];
  assign tail_idx    = tail_q[TAGW-1:0];
  assign full        = (head_q[TAGW] != tail_q[TAGW]) && (head_idx == tail_idx);
  assign empty       = (head_q == tail_q);
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;
  assign res_accept  = res_valid && valid_q[res_tag] && !resolved_q[res_tag];
  assign res_entry   = mem_q[res_tag];
  assign squash      = res_accept && res_mispredict;
  // The frontend is being redirected, so a same-cycle alloc is stale
  assign alloc_fire  = alloc_valid && !full && !squash;
  assign retire      = !empty && valid_q[head_idx] && resolved_q[head_idx];

  // Next-state for pointers and per-entry flags
  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    off_i      = '0;
    // Age of the resolving entry relative to head
    res_off    = res_tag - head_idx;

    if (retire) begin
      valid_d[head_idx]    = 1'b0;
      resolved_d[head_idx] = 1'b0;
      head_d               = head_q + PtrW'(1);
    end

    if (res_accept) resolved_d[res_tag] = 1'b1;

    if (squash) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        off_i = TAGW'(i) - head_idx;
        if (off_i > res_off) valid_d[i] = 1'b0;
      end
      // Rebuild tail from head so the wrap bit keeps occupancy exact
      tail_d = head_q + {1'b0, res_off} + PtrW'(1);
    end else if (alloc_fire) begin
      valid_d[tail_idx]    = 1'b1;
      resolved_d[tail_idx] = 1'b0;
      tail_d               = tail_q + PtrW'(1);
    end
  end

  // Pointer and flag registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
    end
  end

  // Checkpoint payload storage; validity lives in valid_q so no reset needed
  always_ff @(posedge CLK) begin
    if (!reset && alloc_fire) mem_q[tail_idx] <= alloc_entry;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: matches resolutions to checkpoints and drives predictor update/restore.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int unsigned XLEN        = BP_XLEN,
  parameter int unsigned GHR_SIZE    = BP_GHR_SIZE,
  parameter int unsigned PHT_ADDRESS = BP_PHT_ADDRESS,
  parameter int unsigned RAS_ADDRESS = BP_RAS_ADDRESS,
  parameter int unsigned DEPTH       = BP_DEPTH
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  output logic [tag_width(DEPTH)-1:0]  alloc_tag,
  input  logic                         alloc_pred_taken,
  input  logic [XLEN-1:0]              alloc_pred_target,
  input  logic [PHT_ADDRESS-1:0]       alloc_pht_index,
  input  logic [GHR_SIZE-1:0]          alloc_ghr,
  input  logic [RAS_ADDRESS-1:0]       alloc_sp_snap,
  input  logic [2*XLEN-1:0]            alloc_ras_snap,
  input  logic                         res_valid,
  input  logic [tag_width(DEPTH)-1:0]  res_tag,
  input  logic [XLEN-1:0]              res_pc,
  input  logic [XLEN-1:0]              res_target,
  input  logic [XLEN-1:0]              res_return_address,
  input  logic                         res_taken,
  input  logic                         res_is_branch,
  input  logic                         res_is_ret,
  input  logic                         res_is_call,
  output logic                         actual_taken,
  output logic                         mispredict,
  output logic                         restore_ghr,
  output logic                         restore_ras,
  output logic                         update_pht,
  output logic                         update_btb,
  output logic                         update_ras,
  output logic                         ex_is_ret,
  output logic                         ex_is_branch,
  output logic [XLEN-1:0]              actual_target_address,
  output logic [XLEN-1:0]              actual_return_address,
  output logic [XLEN-1:0]              ex_pc,
  output logic [GHR_SIZE-1:0]          ghr_snap,
  output logic [PHT_ADDRESS-1:0]       rb_pht_index,
  output logic [RAS_ADDRESS-1:0]       rb_sp_snap,
  output logic [2*XLEN-1:0]            rb_ras_snap
);

  bp_ckpt_t alloc_entry, res_entry;
  logic     res_accept, res_mis;

  assign alloc_entry = '{pred_taken:  alloc_pred_taken,
                         pred_target: alloc_pred_target,
                         pht_index:   alloc_pht_index,
                         ghr:         alloc_ghr,
                         sp_snap:     alloc_sp_snap,
                         ras_snap:    alloc_ras_snap};

  assign res_mis = bp_mispredict(res_taken, res_target, res_entry);

  branch_ckpt_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK            (CLK),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_entry    (alloc_entry),
    .alloc_ready    (alloc_ready),
    .alloc_tag      (alloc_tag),
    .res_valid      (res_valid),
    .res_tag        (res_tag),
    .res_mispredict (res_mis),
    .res_accept     (res_accept),
    .res_entry      (res_entry)
  );

  // Registered one-cycle pulse of all predictor update/restore outputs
  always_ff @(posedge CLK) begin
    if (reset || !res_accept) begin
      actual_taken          <= 1'b0;
      mispredict            <= 1'b0;
      restore_ghr           <= 1'b0;
      restore_ras           <= 1'b0;
      update_pht            <= 1'b0;
      update_btb            <= 1'b0;
      update_ras            <= 1'b0;
      ex_is_ret             <= 1'b0;
      ex_is_branch          <= 1'b0;
      actual_target_address <= '0;
      actual_return_address <= '0;
      ex_pc                 <= '0;
      ghr_snap              <= '0;
      rb_pht_index          <= '0;
      rb_sp_snap            <= '0;
      rb_ras_snap           <= '0;
    end else begin
      actual_taken          <= res_taken;
      mispredict            <= res_mis;
      restore_ghr           <= res_mis;
      restore_ras           <= res_mis;
      update_pht            <= res_is_branch;
      update_btb            <= res_taken;
      update_ras            <= res_is_call;
      ex_is_ret             <= res_is_ret;
      ex_is_branch          <= res_is_branch;
      actual_target_address <= res_taken ? res_target : (res_pc + XLEN'(4));
      actual_return_address <= res_return_address;
      ex_pc                 <= res_pc;
      // Only conditional branches shift their outcome into history
      ghr_snap              <= res_is_branch ? {res_entry.ghr[GHR_SIZE-2:0], res_taken}
                                             : res_entry.ghr;
      rb_pht_index          <= res_entry.pht_index;
      rb_sp_snap            <= res_entry.sp_snap;
      rb_ras_snap           <= res_entry.ras_snap;
    end
  end

endmodule
